// File: rtl/spi_alu_pkg.sv
// Shared types and constants for the SPI-to-ALU sequencer.
//   FRAME_W  : bits per SPI command frame, shifted MSB first
//   RES_W    : ALU result width returned on MISO
//   OP*_MSB  : field positions inside the received frame
//   RES_ERR  : result substituted when the ALU never answers
package spi_alu_pkg;

    localparam int FRAME_W = 16;
    localparam int RES_W   = 8;

    localparam int OP_W    = 4;
    localparam int OPC_W   = 2;
    localparam int OP1_MSB = 15;
    localparam int OP2_MSB = 11;
    localparam int OPC_MSB = 7;

    localparam logic [RES_W-1:0] RES_ERR = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with single-cycle edge pulses.
//   clk, reset : system clock, async active-high reset
//   async_i    : signal from another clock domain
//   sync_o     : synchronised level
//   rise_o     : one clk pulse on a synchronised 0->1 transition
//   fall_o     : one clk pulse on a synchronised 1->0 transition
// RST_VAL lets an idle-high input (chip select) come out of reset
// without a spurious edge.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_alu_sequencer.sv
// SPI mode-0 slave front end that decodes a command frame, launches one
// ALU operation per frame and returns the result on MISO in the next frame.
//   clk, reset              : system clock, async active-high reset
//   spi_sclk/cs_n/mosi/miso : SPI pins (inputs asynchronous to clk)
//   alu_op1/op2/opcode      : operands held for the ALU
//   alu_start               : one-cycle launch pulse
//   alu_done, alu_result    : ALU handshake and result
//   busy                    : not idle
//   result_valid            : one-cycle pulse when a result is captured
//   frame_err               : one-cycle pulse on short/dropped frame or timeout
//
// state | meaning
// IDLE  | waiting for chip select to fall
// RECV  | shifting a frame in on MOSI, previous result out on MISO
// EXEC  | ALU launched, waiting for alu_done or timeout
// RESP  | result loaded for return; holds until chip select is released
module spi_alu_sequencer
    import spi_alu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic [OP_W-1:0]  alu_op1,
    output logic [OP_W-1:0]  alu_op2,
    output logic [OPC_W-1:0] alu_opcode,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [RES_W-1:0] alu_result,
    output logic             busy,
    output logic             result_valid,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(FRAME_W + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic sclk_level_unused;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_s;
    logic cs_rise_unused;
    logic cs_fall;

    logic mosi_meta_q;
    logic mosi_sync_q;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-2:0] rx_q,      rx_d;
    logic [RES_W-1:0]   tx_q,      tx_d;
    logic [TMR_W-1:0]   timer_q,   timer_d;
    logic [OP_W-1:0]    op1_q,     op1_d;
    logic [OP_W-1:0]    op2_q,     op2_d;
    logic [OPC_W-1:0]   opc_q,     opc_d;
    logic               miso_q,    miso_d;
    logic               start_q,   start_d;
    logic               valid_q,   valid_d;
    logic               err_q,     err_d;
    logic               busy_q,    busy_d;

    // Full frame as it would look once the current MOSI bit is shifted in.
    logic [FRAME_W-1:0] frame;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (spi_sclk),
        .sync_o  (sclk_level_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (spi_cs_n),
        .sync_o  (cs_s),
        .rise_o  (cs_rise_unused),
        .fall_o  (cs_fall)
    );

    assign frame = {rx_q, mosi_sync_q};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        timer_d   = timer_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        opc_d     = opc_q;
        miso_d    = 1'b0;
        start_d   = 1'b0;
        valid_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = '0;
                    // Mode 0: first bit must be on MISO before the first rising edge.
                    miso_d    = tx_q[RES_W-1];
                end
            end
            ST_RECV: begin
                miso_d = miso_q;
                if (cs_s) begin
                    err_d   = 1'b1;
                    miso_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (sclk_fall) begin
                        tx_d   = {tx_q[RES_W-2:0], 1'b0};
                        miso_d = tx_q[RES_W-2];
                    end
                    if (sclk_rise) begin
                        rx_d      = frame[FRAME_W-2:0];
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(FRAME_W - 1)) begin
                            op1_d   = frame[OP1_MSB -: OP_W];
                            op2_d   = frame[OP2_MSB -: OP_W];
                            opc_d   = frame[OPC_MSB -: OPC_W];
                            start_d = 1'b1;
                            timer_d = TMR_W'(TIMEOUT - 1);
                            miso_d  = 1'b0;
                            state_d = ST_EXEC;
                        end
                    end
                end
            end
            ST_EXEC: begin
                if (cs_fall) begin
                    err_d = 1'b1;
                end
                // A done arriving on the last timeout cycle still counts as done.
                if (alu_done) begin
                    tx_d    = alu_result;
                    valid_d = 1'b1;
                    state_d = ST_RESP;
                end else if (timer_q == '0) begin
                    tx_d    = RES_ERR;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_RESP: begin
                if (cs_fall) begin
                    err_d = 1'b1;
                end
                if (cs_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            timer_q     <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            opc_q       <= '0;
            miso_q      <= 1'b0;
            start_q     <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            timer_q     <= timer_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            opc_q       <= opc_d;
            miso_q      <= miso_d;
            start_q     <= start_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign spi_miso     = miso_q;
    assign alu_op1      = op1_q;
    assign alu_op2      = op2_q;
    assign alu_opcode   = opc_q;
    assign alu_start    = start_q;
    assign busy         = busy_q;
    assign result_valid = valid_q;
    assign frame_err    = err_q;

endmodule
